// File: rtl/qcw_ramp_sequencer_pkg.sv
// Shared types and accumulator helpers for the QCW burst ramp sequencer.
// The accumulator is unsigned 8.8 fixed point; the integer byte drives phase_shift.
package qcw_ramp_sequencer_pkg;

    localparam int FRAC_BITS = 8;
    localparam int ACC_W     = 16;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ARM     = 3'd1,
        ST_RAMP    = 3'd2,
        ST_HOLDOFF = 3'd3,
        ST_FAULT   = 3'd4
    } qcw_state_e;

    // One ramp step: widen to catch carry-out, clamp at the end point, never move backwards.
    function automatic logic [ACC_W-1:0] ramp_next(
        input logic [ACC_W-1:0] acc,
        input logic [ACC_W-1:0] step,
        input logic [ACC_W-1:0] end_q
    );
        logic [ACC_W:0] sum;
        sum = {1'b0, acc} + {1'b0, step};
        if (sum >= {1'b0, end_q}) begin
            ramp_next = (acc > end_q) ? acc : end_q;
        end else begin
            ramp_next = sum[ACC_W-1:0];
        end
    endfunction

endpackage

// File: rtl/qcw_ramp_sequencer_if.sv
// Control/status bundle between the burst sequencer and its operator/PLL side.
// The master drives requests and PLL events; the slave (sequencer) drives PLL controls and status.
interface qcw_ramp_sequencer_if #(
    parameter int HOLDOFF_W = 24
);
    logic                 trigger;
    logic                 abort;
    logic                 clear_fault;
    logic [7:0]           ramp_end;
    logic [15:0]          ramp_step;
    logic [15:0]          burst_cycles;
    logic [HOLDOFF_W-1:0] holdoff;
    logic                 pll_cycle_finished;
    logic                 pll_fault;
    logic                 pll_start;
    logic                 pll_halt;
    logic [7:0]           phase_shift;
    logic [15:0]          cycle_limit;
    logic                 busy;
    logic                 done;
    logic                 fault_latched;

    modport master (
        output trigger, abort, clear_fault, ramp_end, ramp_step, burst_cycles, holdoff,
               pll_cycle_finished, pll_fault,
        input  pll_start, pll_halt, phase_shift, cycle_limit, busy, done, fault_latched
    );

    modport slave (
        input  trigger, abort, clear_fault, ramp_end, ramp_step, burst_cycles, holdoff,
               pll_cycle_finished, pll_fault,
        output pll_start, pll_halt, phase_shift, cycle_limit, busy, done, fault_latched
    );

endinterface

// File: rtl/qcw_edge_detect.sv
// Two-flop capture of a level input with a rising-edge pulse taken between the flops.
// The pulse is decoded from registers only, so it never exposes the raw input combinationally.
module qcw_edge_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic rise
);

    logic q1_r;
    logic q2_r;

    // Capture the input, then keep a one-cycle-older copy for comparison.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q1_r <= 1'b0;
            q2_r <= 1'b0;
        end else begin
            q1_r <= din;
            q2_r <= q1_r;
        end
    end

    assign rise = q1_r & ~q2_r;

endmodule

// File: rtl/qcw_ramp_sequencer.sv
// QCW burst controller: trigger -> PLL start, per-drive-cycle phase ramp, holdoff, sticky faults.
// All outputs come straight from flops; faults override every other event in the same cycle.
module qcw_ramp_sequencer
    import qcw_ramp_sequencer_pkg::*;
#(
    parameter logic [7:0] RAMP_START = 8'd16,
    parameter int         HOLDOFF_W  = 24,
    parameter int         WDOG_CLKS  = 4096
) (
    input logic                 clk,
    input logic                 rst_n,
    qcw_ramp_sequencer_if.slave bus
);

    localparam int                WDOG_W    = $clog2(WDOG_CLKS + 1);
    localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(WDOG_CLKS - 1);

    qcw_state_e           state_r;
    logic [ACC_W-1:0]     acc_r;
    logic [ACC_W-1:0]     end_q_r;
    logic [15:0]          cnt_r;
    logic [WDOG_W-1:0]    wdog_r;
    logic [HOLDOFF_W-1:0] hold_r;

    logic                 pll_start_r;
    logic                 pll_halt_r;
    logic [7:0]           phase_r;
    logic [15:0]          cycle_limit_r;
    logic                 busy_r;
    logic                 done_r;
    logic                 fault_r;

    logic                 trig_rise_s;
    logic                 pce_rise_s;
    logic [ACC_W-1:0]     acc_next_s;
    logic [15:0]          cnt_inc_s;

    qcw_edge_detect u_trig_edge (
        .clk  (clk),
        .rst_n(rst_n),
        .din  (bus.trigger),
        .rise (trig_rise_s)
    );

    qcw_edge_detect u_pce_edge (
        .clk  (clk),
        .rst_n(rst_n),
        .din  (bus.pll_cycle_finished),
        .rise (pce_rise_s)
    );

    // Candidate accumulator and drive count for the next cycle-finished event.
    always_comb begin
        acc_next_s = ramp_next(acc_r, bus.ramp_step, end_q_r);
        cnt_inc_s  = cnt_r + 16'd1;
    end

    // Burst FSM with its counters and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= ST_IDLE;
            acc_r         <= {ACC_W{1'b0}};
            end_q_r       <= {ACC_W{1'b0}};
            cnt_r         <= 16'd0;
            wdog_r        <= {WDOG_W{1'b0}};
            hold_r        <= {HOLDOFF_W{1'b0}};
            pll_start_r   <= 1'b0;
            pll_halt_r    <= 1'b0;
            phase_r       <= 8'd0;
            cycle_limit_r <= 16'd0;
            busy_r        <= 1'b0;
            done_r        <= 1'b0;
            fault_r       <= 1'b0;
        end else begin
            pll_start_r <= 1'b0;
            pll_halt_r  <= 1'b0;
            done_r      <= 1'b0;

            if (bus.pll_fault) begin
                state_r    <= ST_FAULT;
                pll_halt_r <= 1'b1;
                fault_r    <= 1'b1;
                phase_r    <= 8'd0;
                busy_r     <= 1'b1;
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        if (trig_rise_s && (bus.burst_cycles != 16'd0)) begin
                            state_r       <= ST_ARM;
                            cycle_limit_r <= bus.burst_cycles;
                            acc_r         <= {RAMP_START, 8'h00};
                            end_q_r       <= {bus.ramp_end, 8'h00};
                            phase_r       <= RAMP_START;
                            pll_start_r   <= 1'b1;
                            busy_r        <= 1'b1;
                        end else begin
                            busy_r <= 1'b0;
                        end
                    end

                    ST_ARM: begin
                        cnt_r   <= 16'd0;
                        wdog_r  <= {WDOG_W{1'b0}};
                        state_r <= ST_RAMP;
                    end

                    ST_RAMP: begin
                        if (!pce_rise_s && (wdog_r == WDOG_LAST)) begin
                            state_r    <= ST_FAULT;
                            pll_halt_r <= 1'b1;
                            fault_r    <= 1'b1;
                            phase_r    <= 8'd0;
                        end else if (bus.abort) begin
                            state_r    <= ST_HOLDOFF;
                            hold_r     <= bus.holdoff;
                            pll_halt_r <= 1'b1;
                            done_r     <= 1'b1;
                        end else if (pce_rise_s) begin
                            acc_r   <= acc_next_s;
                            phase_r <= acc_next_s[ACC_W-1:FRAC_BITS];
                            cnt_r   <= cnt_inc_s;
                            wdog_r  <= {WDOG_W{1'b0}};
                            if (cnt_inc_s == cycle_limit_r) begin
                                state_r <= ST_HOLDOFF;
                                hold_r  <= bus.holdoff;
                                done_r  <= 1'b1;
                            end else begin
                                state_r <= ST_RAMP;
                            end
                        end else begin
                            wdog_r <= wdog_r + {{(WDOG_W-1){1'b0}}, 1'b1};
                        end
                    end

                    ST_HOLDOFF: begin
                        // Trigger edges here are dropped on purpose: no queued bursts.
                        if (hold_r == {HOLDOFF_W{1'b0}}) begin
                            state_r <= ST_IDLE;
                            phase_r <= 8'd0;
                            busy_r  <= 1'b0;
                        end else begin
                            hold_r <= hold_r - {{(HOLDOFF_W-1){1'b0}}, 1'b1};
                        end
                    end

                    ST_FAULT: begin
                        phase_r <= 8'd0;
                        if (bus.clear_fault && !bus.trigger) begin
                            state_r <= ST_IDLE;
                            fault_r <= 1'b0;
                            busy_r  <= 1'b0;
                        end else begin
                            pll_halt_r <= 1'b1;
                        end
                    end

                    default: begin
                        state_r    <= ST_FAULT;
                        pll_halt_r <= 1'b1;
                        fault_r    <= 1'b1;
                        phase_r    <= 8'd0;
                        busy_r     <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign bus.pll_start     = pll_start_r;
    assign bus.pll_halt      = pll_halt_r;
    assign bus.phase_shift   = phase_r;
    assign bus.cycle_limit   = cycle_limit_r;
    assign bus.busy          = busy_r;
    assign bus.done          = done_r;
    assign bus.fault_latched = fault_r;

endmodule

// File: tb/tb_qcw_ramp_sequencer.sv
// Self-checking bench for qcw_ramp_sequencer: scenario tasks with a scoreboard of expected ramp values.
module tb_qcw_ramp_sequencer;

    localparam int HW = 24;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    qcw_ramp_sequencer_if #(.HOLDOFF_W(HW)) bus ();

    qcw_ramp_sequencer #(
        .RAMP_START(8'd16),
        .HOLDOFF_W (HW),
        .WDOG_CLKS (4096)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int start_cnt = 0;
    int done_cnt = 0;

    typedef struct {
        logic [7:0] phase;
        logic       done;
    } exp_t;

    exp_t sb[$];

    always @(negedge clk) begin
        if (bus.pll_start === 1'b1) start_cnt++;
        if (bus.done === 1'b1) done_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic fire_trigger();
        bus.trigger = 1'b1;
        tick();
        bus.trigger = 1'b0;
        tick();
    endtask

    task automatic pulse_pce();
        bus.pll_cycle_finished = 1'b1;
        tick();
        bus.pll_cycle_finished = 1'b0;
        tick();
    endtask

    // Independent reference: linear 8.8 ramp clamped at the end point, flat if start >= end.
    task automatic push_model(input int start, input int endv, input int step, input int n, input int burst);
        exp_t   e;
        longint v;
        for (int i = 1; i <= n; i++) begin
            v = longint'(start) * 256 + longint'(i) * longint'(step);
            if (start >= endv) v = longint'(start) * 256;
            else if (v > longint'(endv) * 256) v = longint'(endv) * 256;
            e.phase = 8'(v / 256);
            e.done  = (i == burst);
            sb.push_back(e);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        ticks(3);
        n_checks++;
        if ({bus.pll_start, bus.pll_halt, bus.done, bus.fault_latched, bus.busy} !== 5'b0) begin
            n_errors++;
            $display("FAIL reset_flags: got %b expected 00000",
                     {bus.pll_start, bus.pll_halt, bus.done, bus.fault_latched, bus.busy});
        end
        n_checks++;
        if (bus.phase_shift !== 8'd0) begin
            n_errors++;
            $display("FAIL reset_phase: got %0d expected 0", bus.phase_shift);
        end
        n_checks++;
        if (bus.cycle_limit !== 16'd0) begin
            n_errors++;
            $display("FAIL reset_cycle_limit: got %0d expected 0", bus.cycle_limit);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic_ramp();
        int   s0;
        exp_t e;
        bus.ramp_end = 8'd48;
        bus.ramp_step = 16'h0400;
        bus.burst_cycles = 16'd10;
        bus.holdoff = HW'(100);
        s0 = start_cnt;
        fire_trigger();
        n_checks++;
        if (bus.pll_start !== 1'b1 || bus.busy !== 1'b1) begin
            n_errors++;
            $display("FAIL basic_start: pll_start=%b busy=%b expected 1 1", bus.pll_start, bus.busy);
        end
        n_checks++;
        if (bus.phase_shift !== 8'd16 || bus.cycle_limit !== 16'd10) begin
            n_errors++;
            $display("FAIL basic_latch: phase=%0d limit=%0d expected 16 10", bus.phase_shift, bus.cycle_limit);
        end
        tick();
        n_checks++;
        if (bus.pll_start !== 1'b0) begin
            n_errors++;
            $display("FAIL basic_start_width: pll_start=%b expected 0", bus.pll_start);
        end
        push_model(16, 48, 16'h0400, 10, 10);
        for (int i = 1; i <= 10; i++) begin
            pulse_pce();
            e = sb.pop_front();
            n_checks++;
            if (bus.phase_shift !== e.phase || bus.done !== e.done) begin
                n_errors++;
                $display("FAIL basic_ramp[%0d]: phase=%0d done=%b expected %0d %b",
                         i, bus.phase_shift, bus.done, e.phase, e.done);
            end
        end
        n_checks++;
        if (start_cnt - s0 != 1 || bus.busy !== 1'b1) begin
            n_errors++;
            $display("FAIL basic_once: starts=%0d busy=%b expected 1 1", start_cnt - s0, bus.busy);
        end
    endtask

    // Entered in the cycle where done is high; holdoff is 100.
    task automatic test_holdoff();
        int s0;
        s0 = start_cnt;
        ticks(50);
        bus.trigger = 1'b1;
        tick();
        bus.trigger = 1'b0;
        ticks(4);
        n_checks++;
        if (start_cnt != s0 || bus.busy !== 1'b1) begin
            n_errors++;
            $display("FAIL holdoff_discard: starts=%0d busy=%b expected %0d 1", start_cnt, bus.busy, s0);
        end
        ticks(55);
        fire_trigger();
        n_checks++;
        if (bus.pll_start !== 1'b1) begin
            n_errors++;
            $display("FAIL holdoff_rearm: pll_start=%b expected 1", bus.pll_start);
        end
        tick();
        n_checks++;
        if (start_cnt != s0 + 1) begin
            n_errors++;
            $display("FAIL holdoff_count: starts=%0d expected %0d", start_cnt, s0 + 1);
        end
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        for (int i = 0; i < 150 && bus.busy !== 1'b0; i++) tick();
        n_checks++;
        if (bus.busy !== 1'b0) begin
            n_errors++;
            $display("FAIL holdoff_idle_timeout: busy=%b expected 0", bus.busy);
        end
    endtask

    task automatic test_abort();
        int   d0;
        exp_t e;
        bus.holdoff = HW'(20);
        bus.burst_cycles = 16'd20;
        bus.ramp_end = 8'd48;
        bus.ramp_step = 16'h0400;
        fire_trigger();
        tick();
        push_model(16, 48, 16'h0400, 3, 20);
        for (int i = 1; i <= 3; i++) begin
            pulse_pce();
            e = sb.pop_front();
            n_checks++;
            if (bus.phase_shift !== e.phase || bus.done !== e.done) begin
                n_errors++;
                $display("FAIL abort_ramp[%0d]: phase=%0d done=%b expected %0d %b",
                         i, bus.phase_shift, bus.done, e.phase, e.done);
            end
        end
        d0 = done_cnt;
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        n_checks++;
        if (bus.pll_halt !== 1'b1 || bus.done !== 1'b1 || bus.busy !== 1'b1) begin
            n_errors++;
            $display("FAIL abort_pulse: halt=%b done=%b busy=%b expected 1 1 1", bus.pll_halt, bus.done, bus.busy);
        end
        tick();
        n_checks++;
        if (bus.pll_halt !== 1'b0 || bus.done !== 1'b0) begin
            n_errors++;
            $display("FAIL abort_width: halt=%b done=%b expected 0 0", bus.pll_halt, bus.done);
        end
        pulse_pce();
        n_checks++;
        if (bus.phase_shift !== 8'd28 || done_cnt - d0 != 1) begin
            n_errors++;
            $display("FAIL abort_frozen: phase=%0d dones=%0d expected 28 1", bus.phase_shift, done_cnt - d0);
        end
        for (int i = 0; i < 60 && bus.busy !== 1'b0; i++) tick();
        n_checks++;
        if (bus.busy !== 1'b0 || bus.phase_shift !== 8'd0) begin
            n_errors++;
            $display("FAIL abort_idle: busy=%b phase=%0d expected 0 0", bus.busy, bus.phase_shift);
        end
    endtask

    task automatic test_fault();
        bus.holdoff = HW'(5);
        bus.burst_cycles = 16'd20;
        fire_trigger();
        tick();
        pulse_pce();
        pulse_pce();
        bus.pll_fault = 1'b1;
        tick();
        bus.pll_fault = 1'b0;
        n_checks++;
        if (bus.fault_latched !== 1'b1 || bus.pll_halt !== 1'b1 || bus.phase_shift !== 8'd0 || bus.busy !== 1'b1) begin
            n_errors++;
            $display("FAIL fault_entry: fault=%b halt=%b phase=%0d busy=%b expected 1 1 0 1",
                     bus.fault_latched, bus.pll_halt, bus.phase_shift, bus.busy);
        end
        bus.clear_fault = 1'b1;
        bus.trigger = 1'b1;
        ticks(3);
        n_checks++;
        if (bus.fault_latched !== 1'b1 || bus.pll_halt !== 1'b1) begin
            n_errors++;
            $display("FAIL fault_clear_blocked: fault=%b halt=%b expected 1 1", bus.fault_latched, bus.pll_halt);
        end
        bus.trigger = 1'b0;
        tick();
        bus.clear_fault = 1'b0;
        n_checks++;
        if (bus.fault_latched !== 1'b0 || bus.pll_halt !== 1'b0 || bus.busy !== 1'b0) begin
            n_errors++;
            $display("FAIL fault_clear: fault=%b halt=%b busy=%b expected 0 0 0",
                     bus.fault_latched, bus.pll_halt, bus.busy);
        end
    endtask

    task automatic test_watchdog();
        bus.burst_cycles = 16'd20;
        fire_trigger();
        ticks(4000);
        n_checks++;
        if (bus.fault_latched !== 1'b0 || bus.busy !== 1'b1) begin
            n_errors++;
            $display("FAIL wdog_early: fault=%b busy=%b expected 0 1", bus.fault_latched, bus.busy);
        end
        for (int i = 0; i < 200 && bus.fault_latched !== 1'b1; i++) tick();
        n_checks++;
        if (bus.fault_latched !== 1'b1 || bus.pll_halt !== 1'b1) begin
            n_errors++;
            $display("FAIL wdog_fault: fault=%b halt=%b expected 1 1", bus.fault_latched, bus.pll_halt);
        end
        bus.clear_fault = 1'b1;
        tick();
        bus.clear_fault = 1'b0;
        tick();
    endtask

    task automatic test_zero_cycles();
        int s0;
        int d0;
        bus.burst_cycles = 16'd0;
        s0 = start_cnt;
        d0 = done_cnt;
        fire_trigger();
        ticks(5);
        n_checks++;
        if (start_cnt != s0 || done_cnt != d0 || bus.busy !== 1'b0) begin
            n_errors++;
            $display("FAIL zero_cycles: starts=%0d dones=%0d busy=%b expected %0d %0d 0",
                     start_cnt, done_cnt, bus.busy, s0, d0);
        end
    endtask

    task automatic test_saturation();
        exp_t e;
        bus.ramp_end = 8'd255;
        bus.ramp_step = 16'hFFFF;
        bus.burst_cycles = 16'd4;
        bus.holdoff = HW'(0);
        fire_trigger();
        tick();
        push_model(16, 255, 16'hFFFF, 4, 4);
        for (int i = 1; i <= 4; i++) begin
            pulse_pce();
            e = sb.pop_front();
            n_checks++;
            if (bus.phase_shift !== e.phase || bus.done !== e.done) begin
                n_errors++;
                $display("FAIL sat_ramp[%0d]: phase=%0d done=%b expected %0d %b",
                         i, bus.phase_shift, bus.done, e.phase, e.done);
            end
        end
        ticks(2);
        n_checks++;
        if (bus.busy !== 1'b0 || bus.phase_shift !== 8'd0) begin
            n_errors++;
            $display("FAIL sat_zero_holdoff: busy=%b phase=%0d expected 0 0", bus.busy, bus.phase_shift);
        end
    endtask

    task automatic test_reset_mid_ramp();
        exp_t e;
        bus.ramp_end = 8'd48;
        bus.ramp_step = 16'h0400;
        bus.burst_cycles = 16'd20;
        bus.holdoff = HW'(5);
        fire_trigger();
        tick();
        pulse_pce();
        pulse_pce();
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({bus.pll_start, bus.pll_halt, bus.done, bus.fault_latched, bus.busy} !== 5'b0 ||
            bus.phase_shift !== 8'd0 || bus.cycle_limit !== 16'd0) begin
            n_errors++;
            $display("FAIL async_reset: flags=%b phase=%0d limit=%0d expected 00000 0 0",
                     {bus.pll_start, bus.pll_halt, bus.done, bus.fault_latched, bus.busy},
                     bus.phase_shift, bus.cycle_limit);
        end
        ticks(2);
        rst_n = 1'b1;
        tick();
        fire_trigger();
        n_checks++;
        if (bus.pll_start !== 1'b1 || bus.phase_shift !== 8'd16 || bus.cycle_limit !== 16'd20) begin
            n_errors++;
            $display("FAIL post_reset_start: start=%b phase=%0d limit=%0d expected 1 16 20",
                     bus.pll_start, bus.phase_shift, bus.cycle_limit);
        end
        tick();
        push_model(16, 48, 16'h0400, 1, 20);
        pulse_pce();
        e = sb.pop_front();
        n_checks++;
        if (bus.phase_shift !== e.phase || bus.done !== e.done) begin
            n_errors++;
            $display("FAIL post_reset_ramp: phase=%0d done=%b expected %0d %b",
                     bus.phase_shift, bus.done, e.phase, e.done);
        end
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        ticks(10);
    endtask

    initial begin
        bus.trigger = 1'b0;
        bus.abort = 1'b0;
        bus.clear_fault = 1'b0;
        bus.ramp_end = 8'd48;
        bus.ramp_step = 16'h0400;
        bus.burst_cycles = 16'd10;
        bus.holdoff = HW'(100);
        bus.pll_cycle_finished = 1'b0;
        bus.pll_fault = 1'b0;

        test_reset();
        test_basic_ramp();
        test_holdoff();
        test_abort();
        test_fault();
        test_watchdog();
        test_zero_cycles();
        test_saturation();
        test_reset_mid_ramp();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
